// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: operand beat, result beat with flags,
// and the running count of delivered results.
interface logic_unit_pipe_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_result;
  logic               out_zero;
  logic               out_parity;
  logic [COUNT_W-1:0] xfer_count;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_parity, xfer_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_parity, xfer_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit: valid/ready on both sides, PIPE_DEPTH
// backpressured stages carrying result plus zero/parity flags, output transfer counter.
module logic_unit_pipe #(
  parameter int WIDTH      = 8,
  parameter int PIPE_DEPTH = 2,
  parameter int COUNT_W    = 16
) (
  input logic              clk,
  input logic              rst_n,
  logic_unit_pipe_if.slave bus
);
  localparam int LAST = PIPE_DEPTH - 1;

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("logic_unit_pipe: PIPE_DEPTH must be in 1..4");
  end

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOT  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_BUF  = 3'b111
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
  } stage_t;

  op_e                   w_op;
  stage_t                w_new;
  logic [PIPE_DEPTH-1:0] w_adv;
  logic [PIPE_DEPTH-1:0] w_src_valid;
  stage_t                w_src [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0] r_valid;
  stage_t                r_stage [PIPE_DEPTH];
  logic [COUNT_W-1:0]    r_xfer_count;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_op         = op_e'(bus.in_op);
    w_new.result = '0;
    case (w_op)
      OP_AND:  w_new.result = bus.in_a & bus.in_b;
      OP_OR:   w_new.result = bus.in_a | bus.in_b;
      OP_XOR:  w_new.result = bus.in_a ^ bus.in_b;
      OP_NOT:  w_new.result = ~bus.in_a;
      OP_NAND: w_new.result = ~(bus.in_a & bus.in_b);
      OP_NOR:  w_new.result = ~(bus.in_a | bus.in_b);
      OP_XNOR: w_new.result = ~(bus.in_a ^ bus.in_b);
      OP_BUF:  w_new.result = bus.in_a;
      default: w_new.result = '0;
    endcase
    w_new.zero   = (w_new.result == '0);
    w_new.parity = ^w_new.result;
  end

  // A stage advances when it is empty or everything downstream of it can move;
  // accumulating from the output end gives the same answer without a chained signal.
  always_comb begin
    logic w_room;
    w_adv  = '0;
    w_room = bus.out_ready;
    for (int i = LAST; i >= 0; i--) begin
      w_room   = w_room | ~r_valid[i];
      w_adv[i] = w_room;
    end
  end

  always_comb begin
    w_src_valid = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) w_src[i] = w_new;
    w_src_valid[0] = bus.in_valid;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      w_src_valid[i] = r_valid[i-1];
      w_src[i]       = r_stage[i-1];
    end
  end

  // NOTE: sequential state uses <= so each stage samples its neighbour's pre-edge value.
  // NOTE: stage data is reset as well, because out_result/out_zero/out_parity must read 0/1/0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_stage[i] <= '{result: '0, zero: 1'b1, parity: 1'b0};
      end
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        if (w_adv[i]) begin
          r_valid[i] <= w_src_valid[i];
          if (w_src_valid[i]) r_stage[i] <= w_src[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_count <= '0;
    end else if (r_valid[LAST] && bus.out_ready) begin
      r_xfer_count <= r_xfer_count + COUNT_W'(1);
    end
  end

  assign bus.in_ready   = rst_n & w_adv[0];
  assign bus.out_valid  = r_valid[LAST];
  assign bus.out_result = r_stage[LAST].result;
  assign bus.out_zero   = r_stage[LAST].zero;
  assign bus.out_parity = r_stage[LAST].parity;
  assign bus.xfer_count = r_xfer_count;
endmodule
